// File: rtl/id_decode_queue_if.sv
// id_decode_queue_if
// Bundles the fetch-side and decode-side handshakes of id_decode_queue.
//   slave  modport: the queue (accepts in_*, presents out_*)
//   master modport: the producer/consumer around it (fetch + downstream)
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high; the sender holds its payload stable
// while valid && !ready, and ready never depends combinationally on valid.
// Signals:
//   in_valid / in_ready / in_instr[31:0] / in_pc[PC_W-1:0]   fetch side
//   out_valid / out_ready / out_instr[31:0] / out_pc[PC_W-1:0]
//   out_ctrl[16:0] / out_delayslot                             decode side
interface id_decode_queue_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [16:0]     out_ctrl;
  logic            out_delayslot;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_ctrl, out_delayslot
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_ctrl, out_delayslot
  );
endinterface

// File: rtl/id_decode_queue.sv
// id_decode_queue
// Buffered main-decode stage: instructions are decoded into a 17-bit control
// word as they are enqueued and held in a DEPTH-entry FIFO in front of ID/EX.
// Each entry is tagged with whether it sits in a branch delay slot.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   flush       discard all entries and the delay-slot state
//   bus         id_decode_queue_if.slave (in_* handshake, out_* head entry)
//   count       occupancy, 0..DEPTH
// Optional feature: define CP0_INSN_EN to decode ERET/MTC0/MFC0; without it
// every COP0 encoding is a reserved instruction and ctrl[2:0] stay zero.
// out_ctrl, MSB->LSB: memwrite regwrite regdst alusrc branch memtoreg jump
//   jal jr bal hilo_en break syscall reserve eret mtc0_we mfc0
module id_decode_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  id_decode_queue_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [16:0] C_IMM   = 17'h0A000;
  localparam logic [16:0] C_LOAD  = 17'h0A800;
  localparam logic [16:0] C_STORE = 17'h12000;
  localparam logic [16:0] C_J     = 17'h00400;
  localparam logic [16:0] C_JAL   = 17'h08200;
  localparam logic [16:0] C_BR    = 17'h01000;
  localparam logic [16:0] C_BAL   = 17'h09080;
  localparam logic [16:0] C_ALU   = 17'h0C000;
  localparam logic [16:0] C_HILO  = 17'h00040;
  localparam logic [16:0] C_JR    = 17'h00100;
  localparam logic [16:0] C_JALR  = 17'h0C100;
  localparam logic [16:0] C_SYS   = 17'h00010;
  localparam logic [16:0] C_BRK   = 17'h00020;
  localparam logic [16:0] C_RSV   = 17'h00008;

  function automatic logic [16:0] decode(input logic [31:0] i);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [16:0] d;
    op = i[31:26];
    fn = i[5:0];
    rs = i[25:21];
    rt = i[20:16];
    d  = C_RSV;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B, 6'h10, 6'h12:               d = C_ALU;
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: d = C_HILO;
          6'h08:                                    d = C_JR;
          6'h09:                                    d = C_JALR;
          6'h0C:                                    d = C_SYS;
          6'h0D:                                    d = C_BRK;
          default:                                  d = C_RSV;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: d = C_BR;
          5'h10, 5'h11: d = C_BAL;
          default:      d = C_RSV;
        endcase
      end
      6'h02:                             d = C_J;
      6'h03:                             d = C_JAL;
      6'h04, 6'h05, 6'h06, 6'h07:        d = C_BR;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:        d = C_IMM;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: d = C_LOAD;
      6'h28, 6'h29, 6'h2B:               d = C_STORE;
`ifdef CP0_INSN_EN
      6'h10: begin
        if (i == 32'h42000018)                     d = 17'h00004;
        else if (rs == 5'h04 && i[10:3] == 8'h00) d = 17'h00002;
        else if (rs == 5'h00 && i[10:3] == 8'h00) d = 17'h08001;
        else                                       d = C_RSV;
      end
`endif
      default: d = C_RSV;
    endcase
    return d;
  endfunction

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [16:0]     mem_ctrl  [DEPTH];
  logic            mem_ds    [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_r;
  logic          ds;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [16:0]   in_ctrl;
  logic          in_is_cti;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == '0);
  assign push      = bus.in_valid && !full && !flush;
  assign pop       = !empty && bus.out_ready && !flush;
  assign in_ctrl   = decode(bus.in_instr);
  // Any control transfer (branch, jump, jal, jr, bal) makes the next
  // enqueued instruction its delay slot.
  assign in_is_cti = in_ctrl[12] | in_ctrl[10] | in_ctrl[9] | in_ctrl[8] | in_ctrl[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_r <= '0;
      ds      <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_instr[k] <= '0;
        mem_pc[k]    <= '0;
        mem_ctrl[k]  <= '0;
        mem_ds[k]    <= 1'b0;
      end
    end else if (flush) begin
      // Storage is left alone: consumers qualify out_* with out_valid.
      wptr    <= '0;
      rptr    <= '0;
      count_r <= '0;
      ds      <= 1'b0;
    end else begin
      if (push) begin
        mem_instr[wptr] <= bus.in_instr;
        mem_pc[wptr]    <= bus.in_pc;
        mem_ctrl[wptr]  <= in_ctrl;
        mem_ds[wptr]    <= ds;
        ds              <= in_is_cti;
        wptr            <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.in_ready      = !full;
  assign bus.out_valid     = !empty;
  assign bus.out_instr     = mem_instr[rptr];
  assign bus.out_pc        = mem_pc[rptr];
  assign bus.out_ctrl      = mem_ctrl[rptr];
  assign bus.out_delayslot = mem_ds[rptr];
  assign count             = count_r;
endmodule

// File: tb/tb_id_decode_queue.sv
module tb_id_decode_queue;
  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int EW    = 32 + PC_W + 17 + 1;

  logic clk;
  logic rst;
  logic flush;
  logic [$clog2(DEPTH+1)-1:0] count;

  id_decode_queue_if #(.PC_W(PC_W)) bus ();

  id_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: compares the head on every accepted pop
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && !flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got instr 0x%0h with nothing expected", bus.out_instr);
      end else begin
        e = exp_q.pop_front();
        check("out_instr", bus.out_instr, e[EW-1 -: 32]);
        check("out_pc", bus.out_pc, e[EW-33 -: PC_W]);
        check("out_ctrl", {15'd0, bus.out_ctrl}, {15'd0, e[17:1]});
        check("out_delayslot", {31'd0, bus.out_delayslot}, {31'd0, e[0]});
      end
    end
  end

  // driver: called just after a rising edge; offers one instruction for one cycle
  task automatic push(input logic [31:0] instr, input logic [PC_W-1:0] pc,
                      input logic [16:0] exp_ctrl, input logic exp_ds,
                      output logic accepted);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    @(negedge clk);
    accepted = bus.in_ready && !flush;
    if (accepted) exp_q.push_back({instr, pc, exp_ctrl, exp_ds});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push_chk(input logic [31:0] instr, input logic [PC_W-1:0] pc,
                          input logic [16:0] exp_ctrl, input logic exp_ds);
    logic acc;
    push(instr, pc, exp_ctrl, exp_ds, acc);
    check("accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_count"}, {30'd0, count}, 32'd0);
    check({tag, "_out_instr"}, bus.out_instr, 32'd0);
    check({tag, "_out_pc"}, bus.out_pc, 32'd0);
    check({tag, "_out_ctrl"}, {15'd0, bus.out_ctrl}, 32'd0);
    check({tag, "_out_ds"}, {31'd0, bus.out_delayslot}, 32'd0);
  endtask

  initial begin : stim
    logic acc;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // single instruction
    bus.out_ready = 1'b1;
    push_chk(32'h24420001, 32'h00000100, 17'h0A000, 1'b0);
    check("single_count", {30'd0, count}, 32'd1);
    check("single_out_valid", {31'd0, bus.out_valid}, 32'd1);
    drain("single_drain");

    // delay-slot tagging and decode coverage
    push_chk(32'h10000003, 32'h00000200, 17'h01000, 1'b0); // BEQ
    push_chk(32'h00851021, 32'h00000204, 17'h0C000, 1'b1); // ADDU in slot
    push_chk(32'hAFBF0010, 32'h00000208, 17'h12000, 1'b0); // SW
    push_chk(32'h0C000010, 32'h0000020C, 17'h08200, 1'b0); // JAL
    push_chk(32'h8FBF0010, 32'h00000210, 17'h0A800, 1'b1); // LW in slot
    push_chk(32'h08000000, 32'h00000214, 17'h00400, 1'b0); // J
    push_chk(32'h04100002, 32'h00000218, 17'h09080, 1'b1); // BLTZAL in slot
    push_chk(32'h04050000, 32'h0000021C, 17'h00008, 1'b1); // REGIMM rt=5
    push_chk(32'h00850018, 32'h00000220, 17'h00040, 1'b0); // MULT
    push_chk(32'h00A0F809, 32'h00000224, 17'h0C100, 1'b0); // JALR
    push_chk(32'h0000000C, 32'h00000228, 17'h00010, 1'b1); // SYSCALL in slot
    push_chk(32'h0000000D, 32'h0000022C, 17'h00020, 1'b0); // BREAK
    push_chk(32'h00001010, 32'h00000230, 17'h0C000, 1'b0); // MFHI
    // reserved instructions
    push_chk(32'hFC000000, 32'h00000234, 17'h00008, 1'b0);
    push_chk(32'h0000003F, 32'h00000238, 17'h00008, 1'b0);
`ifdef CP0_INSN_EN
    push_chk(32'h42000018, 32'h0000023C, 17'h00004, 1'b0); // ERET
    push_chk(32'h40804800, 32'h00000240, 17'h00002, 1'b0); // MTC0
    push_chk(32'h40026000, 32'h00000244, 17'h08001, 1'b0); // MFC0
`else
    push_chk(32'h42000018, 32'h0000023C, 17'h00008, 1'b0);
    push_chk(32'h40804800, 32'h00000240, 17'h00008, 1'b0);
`endif
    drain("decode_drain");

    // full queue, then flush with a concurrent push
    bus.out_ready = 1'b0;
    push_chk(32'h10000003, 32'h00000300, 17'h01000, 1'b0); // BEQ
    push_chk(32'h14000003, 32'h00000304, 17'h01000, 1'b1); // BNE, leaves ds=1
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full_count", {30'd0, count}, 32'd2);
    push(32'h24420001, 32'h00000308, 17'h0A000, 1'b0, acc);
    check("full_reject", {31'd0, acc}, 32'd0);
    check("full_count_hold", {30'd0, count}, 32'd2);
    check("full_head_instr", bus.out_instr, 32'h10000003);
    flush = 1'b1;
    push(32'h24420001, 32'h0000030C, 17'h0A000, 1'b0, acc);
    flush = 1'b0;
    exp_q.delete();
    check("flush_count", {30'd0, count}, 32'd0);
    check("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    push_chk(32'h03E00008, 32'h00000310, 17'h00100, 1'b0); // JR, ds cleared
    drain("flush_drain");

    // simultaneous push/pop at count = 1
    bus.out_ready = 1'b0;
    push_chk(32'h00851021, 32'h00000400, 17'h0C000, 1'b1); // after JR
    check("pp_count_before", {30'd0, count}, 32'd1);
    bus.out_ready = 1'b1;
    push_chk(32'h24420002, 32'h00000404, 17'h0A000, 1'b0);
    check("pp_count_after", {30'd0, count}, 32'd1);
    check("pp_head_instr", bus.out_instr, 32'h24420002);
    drain("pp_drain");

    // mid-stream reset
    bus.out_ready = 1'b0;
    push_chk(32'h00851021, 32'h00000500, 17'h0C000, 1'b0);
    push_chk(32'h10000003, 32'h00000504, 17'h01000, 1'b0); // leaves ds=1
    check("mid_count", {30'd0, count}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_reset_outputs("midrst");
    bus.out_ready = 1'b1;
    push_chk(32'h00851021, 32'h00000508, 17'h0C000, 1'b0); // ds cleared by reset
    drain("final_drain");

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_decode_queue.md
# id_decode_queue

Buffered main-decode stage for the MIPS pipeline: accepts fetched instructions over a valid/ready handshake, decodes each on enqueue into a control word, and holds up to DEPTH decoded entries in a FIFO in front of the ID/EX boundary. It adds three things to the plain combinational decoder:
- branch-delay-slot tagging
- reserved-instruction detection for unknown R-type functs
- pipeline flush

It sits between the IF/ID register and the hazard/regfile logic.

## Interface
Parameters:
- DEPTH, 2, queue entries; power of two, ≥2
- PC_W, 32, PC width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard all entries and delay-slot state
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  queue can accept (= not full)
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  head entry valid (= not empty)
- out_ready  in  1  downstream consumes head
- out_instr  out  32  head instruction
- out_pc  out  PC_W  head PC
- out_ctrl  out  17  head control word
- out_delayslot  out  1  head is in a branch delay slot
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
out_ctrl bit order, MSB→LSB:
- memwrite[16], regwrite[15], regdst[14], alusrc[13], branch[12], memtoreg[11]
- jump[10], jal[9], jr[8], bal[7], hilo_en[6]
- break[5], syscall[4], reserve[3], eret[2], mtc0_we[1], mfc0[0]

Decode (MIPS32 encodings):
- ANDI/ORI/XORI/LUI/ADDI/ADDIU/SLTI/SLTIU: 0x0A000
- LB/LBU/LH/LHU/LW: 0x0A800
- SB/SH/SW: 0x12000
- J: 0x00400
- JAL: 0x08200
- BEQ/BNE/BGTZ/BLEZ: 0x01000
- REGIMM, by rt:
  - BLTZ/BGEZ: 0x01000
  - BLTZAL/BGEZAL: 0x09080
  - other rt: 0x00008
- SPECIAL, by funct:
  - ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV (0x20–0x27, 0x2A, 0x2B, 0x00, 0x02–0x04, 0x06, 0x07): 0x0C000
  - MFHI/MFLO: 0x0C000
  - MTHI/MTLO/MULT/MULTU/DIV/DIVU: 0x00040
  - JR: 0x00100
  - JALR: 0x0C100
  - SYSCALL: 0x00010
  - BREAK: 0x00020
  - any other funct: 0x00008
- COP0: see Configuration.
- Any other opcode: 0x00008, with reserve as the only bit set.

Enqueue and dequeue:
- Enqueue when in_valid && in_ready && !flush. Store instr, pc, decoded ctrl and the current delay-slot flag.
- Delay-slot register ds: on enqueue, ds ← OR of (branch, jump, jal, jr, bal) of the enqueued ctrl. The entry's out_delayslot is the value of ds before that update.
- Dequeue when out_valid && out_ready && !flush. The head pointer advances.
- Push and pop in the same cycle: count is unchanged. When full, in_ready = 0 even if out_ready = 1; there is no full-bypass.
- Pointers wrap modulo DEPTH.

Flush:
- Next cycle: count = 0, pointers = 0, ds = 0.
- Any push or pop in the flush cycle is ignored.

## Timing
- Reset values: in_ready = 1, out_valid = 0, count = 0, out_instr/out_pc/out_ctrl/out_delayslot = 0, ds = 0. Storage is cleared to zero.
- Latency: an entry enqueued in cycle N is presented on out_* from cycle N+1. out_* are read from FIFO storage and are combinational from the read pointer only.
- While the queue is empty, out_* hold the last-read entry or zero; consumers qualify them with out_valid.
- out_* are stable while out_valid && !out_ready.
- rst has priority over flush; flush has priority over push/pop.
- Reset asserted mid-operation behaves identically to reset from power-up.

## Configuration
Macro CP0_INSN_EN.
- Defined — COP0 opcode decodes as:
  - ERET (0x42000018): 0x00004
  - rs = 0x04 with instr[10:3] = 0 (MTC0): 0x00002
  - rs = 0x00 with instr[10:3] = 0 (MFC0): 0x08001
  - any other COP0 encoding: 0x00008
- Undefined: every COP0 encoding decodes to 0x00008. Bits 2, 1 and 0 are tied to 0.

## Test plan
- Single instruction: reset; push 0x24420001 (ADDIU) with out_ready = 1 → next cycle out_valid = 1, out_ctrl = 0x0A000, out_delayslot = 0, count = 1.
- Delay-slot tagging: push 0x10000003 (BEQ) then 0x00851021 (ADDU) → out_ctrl 0x01000 with delayslot 0, then 0x0C000 with delayslot 1. A third push 0xAFBF0010 (SW) → 0x12000 with delayslot 0.
- Reserved-instruction detection: push 0xFC000000 → 0x00008. Push 0x0000003F (unknown funct) → 0x00008.
- Full queue and flush: DEPTH = 2, out_ready = 0, push 3 instructions → in_ready = 0 after the 2nd, count = 2, the 3rd is not accepted. Assert flush plus in_valid → next cycle count = 0, out_valid = 0. Then push a JR (funct 0x08) → 0x00100 with delayslot 0.
- COP0 with the macro defined: push 0x42000018 → 0x00004. Push 0x40804800 (MTC0) → 0x00002.
- COP0 without the macro: push 0x42000018 → 0x00008.
- Simultaneous push/pop at count = 1 → count stays 1 and FIFO order is preserved.
- Mid-stream reset: rst with count = 2 → all outputs at reset values next cycle.
